// File: rtl/aes_stim_ctrl.sv
// Drives an AES-128 core one block at a time while work is high, feeding each result back as the next input.
// Latency: launch 1 cycle after work seen in IDLE; relaunch 2 cycles after aes_done. Flow: start/done handshake, WAIT aborts after TIMEOUT cycles.
module aes_stim_ctrl #(
    parameter logic [127:0] SEED    = 128'h00112233445566778899aabbccddeeff,
    parameter logic [127:0] KEY     = 128'h000102030405060708090a0b0c0d0e0f,
    parameter int unsigned  TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         work,
    input  logic         enc,
    output logic         aes_start,
    output logic         aes_enc,
    output logic [127:0] aes_key,
    output logic [127:0] aes_din,
    input  logic         aes_done,
    input  logic [127:0] aes_dout,
    output logic         busy,
    output logic [31:0]  blk_cnt,
    output logic [31:0]  sig,
    output logic         err
);
    localparam int unsigned   TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_UPDATE = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_work_d;
    logic [TW-1:0] r_timer;
    logic [127:0]  r_dout;
    logic [127:0]  r_din;
    logic          r_enc;
    logic [31:0]   r_blk_cnt;
    logic [31:0]   r_sig;
    logic          r_err;

    logic          w_run_rise;
    logic          w_timeout;
    logic [31:0]   w_fold;

    assign w_run_rise = work & ~r_work_d;
    assign w_timeout  = (r_timer == TIMER_LAST);
    assign w_fold     = r_dout[127:96] ^ r_dout[95:64] ^ r_dout[63:32] ^ r_dout[31:0];

    // aes_done has priority over the timeout on the last WAIT cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (work) w_state_nxt = S_LAUNCH;
            S_LAUNCH: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (aes_done)       w_state_nxt = S_UPDATE;
                else if (w_timeout) w_state_nxt = S_IDLE;
            end
            S_UPDATE: w_state_nxt = work ? S_LAUNCH : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_work_d  <= 1'b0;
            r_timer   <= '0;
            r_dout    <= '0;
            r_din     <= SEED;
            r_enc     <= 1'b1;
            r_blk_cnt <= '0;
            r_sig     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_work_d <= work;
            case (r_state)
                S_IDLE: begin
                    // a new run restarts the chain; launch may follow on this same edge
                    if (w_run_rise) begin
                        r_din     <= SEED;
                        r_blk_cnt <= '0;
                        r_sig     <= '0;
                        r_err     <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    r_enc   <= enc;
                    r_timer <= '0;
                end
                S_WAIT: begin
                    if (aes_done) begin
                        r_dout <= aes_dout;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                        if (w_timeout) r_err <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    r_blk_cnt <= r_blk_cnt + 32'd1;
                    r_sig     <= {r_sig[30:0], r_sig[31]} ^ w_fold;
                    r_din     <= r_dout;
                end
                default: ;
            endcase
        end
    end

    assign aes_start = (r_state == S_LAUNCH);
    assign busy      = (r_state != S_IDLE);
    assign aes_enc   = r_enc;
    assign aes_key   = KEY;
    assign aes_din   = r_din;
    assign blk_cnt   = r_blk_cnt;
    assign sig       = r_sig;
    assign err       = r_err;

endmodule

// File: tb/tb_aes_stim_ctrl.sv
// Bench for aes_stim_ctrl: stand-in AES core plus a block-window reference model checked every cycle.
module tb_aes_stim_ctrl;
    localparam logic [127:0] SEED = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam int           TMO  = 16;

    logic         clk = 1'b0;
    logic         rst_n, work, enc, aes_start, aes_enc, aes_done, busy, err;
    logic [127:0] aes_key, aes_din, aes_dout;
    logic [31:0]  blk_cnt, sig;

    aes_stim_ctrl #(.SEED(SEED), .KEY(KEY), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .work(work), .enc(enc),
        .aes_start(aes_start), .aes_enc(aes_enc), .aes_key(aes_key), .aes_din(aes_din),
        .aes_done(aes_done), .aes_dout(aes_dout), .busy(busy),
        .blk_cnt(blk_cnt), .sig(sig), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // reference model: a block occupies cycles [m_s, end]; end is done+1 or m_s+TMO
    bit           m_busy;
    int           m_s, m_done;
    logic [127:0] m_dout;
    bit           wp;
    logic         e_start, e_busy, e_err, e_enc;
    logic [31:0]  e_cnt, e_sig;
    logic [127:0] e_din;

    // stand-in core
    bit           c_pend;
    int           c_s, c_due;
    logic [127:0] c_din;
    logic         c_enc;
    int           core_lat;
    bit           stray_en;

    int n_starts, last_start, last_gap;

    typedef struct {
        int          lat;
        logic        enc;
        int          nblk;
        logic [31:0] exp_cnt;
        int          exp_gap;
        logic        exp_err;
    } vec_t;

    function automatic logic [127:0] core_fn(input logic [127:0] x, input logic e);
        if (e && x == SEED) return CT;
        if (!e && x == CT)  return SEED;
        return e ? ({x[126:0], x[127]} ^ 128'h5a5a_0f0f_a5a5_f0f0_1234_5678_9abc_def0)
                 : ({x[0], x[127:1]} ^ 128'hc3c3_3c3c_0101_1010_fedc_ba98_7654_3210);
    endfunction

    function automatic logic [31:0] sig_step(input logic [31:0] s, input logic [127:0] d);
        logic [31:0] r;
        r = {s[30:0], s[31]};
        for (int w = 0; w < 4; w++) r = r ^ d[32*w +: 32];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = -1; wp = 0; c_pend = 0;
        e_start = 0; e_busy = 0; e_err = 0; e_enc = 1'b1;
        e_cnt = '0; e_sig = '0; e_din = SEED;
    endtask

    task automatic tick();
        bit ended_upd, ended_tmo;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else begin
            ended_upd = m_busy && m_done >= 0 && (cyc - 1 == m_done + 1);
            ended_tmo = m_busy && m_done < 0 && (cyc - 1 == m_s + TMO);
            if (ended_upd) begin
                e_cnt = e_cnt + 32'd1;
                e_sig = sig_step(e_sig, m_dout);
                e_din = m_dout;
            end
            if (ended_tmo) e_err = 1'b1;
            if (!m_busy && work && !wp) begin
                e_din = SEED; e_cnt = '0; e_sig = '0; e_err = 1'b0;
            end
            if (!m_busy || ended_upd || ended_tmo) begin
                m_busy = work && !ended_tmo;
                if (m_busy) begin m_s = cyc; m_done = -1; end
            end
            if (m_busy && cyc == m_s + 1) e_enc = enc;
            wp = work;
        end
        e_start = m_busy && (cyc == m_s);
        e_busy  = m_busy;
        chk("aes_start", aes_start, e_start);
        chk("busy", busy, e_busy);
        chk("err", err, e_err);
        chk("blk_cnt", blk_cnt, e_cnt);
        chk("sig", sig, e_sig);
        chk("aes_din", aes_din, e_din);
        chk("aes_enc", aes_enc, e_enc);
        chk("aes_key", aes_key, KEY);
        if (aes_start) begin
            if (n_starts > 0) last_gap = cyc - last_start;
            last_start = cyc;
            n_starts++;
        end
        // core answers core_lat cycles after each start; 0 means never
        if (!rst_n) c_pend = 0;
        else if (aes_start) begin
            c_pend = (core_lat > 0); c_s = cyc; c_due = cyc + core_lat; c_din = aes_din;
        end
        if (c_pend && cyc == c_s + 1) c_enc = aes_enc;
        aes_done = 1'b0;
        aes_dout = {$urandom, $urandom, $urandom, $urandom};
        if (c_pend && cyc == c_due) begin
            aes_done = 1'b1; aes_dout = core_fn(c_din, c_enc); c_pend = 0;
        end else if (!c_pend && stray_en && $urandom_range(0, 19) == 0) begin
            aes_done = 1'b1;
        end
        if (aes_done && rst_n && m_busy && m_done < 0 && cyc > m_s && cyc <= m_s + TMO) begin
            m_done = cyc; m_dout = aes_dout;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_start(input int budget, input string what);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin tick(); seen = aes_start; end
        chk(what, seen, 1'b1);
    endtask

    task automatic wait_idle(input int budget, input string what);
        bit idle = 0;
        for (int i = 0; i < budget && !idle; i++) begin tick(); idle = !busy; end
        chk(what, idle, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl[6];
        logic [127:0] ct_v;
        logic [31:0]  ct_fold;
        int           s, n0;

        tbl[0] = '{12, 1'b1, 5, 32'd5, 14, 1'b0};
        tbl[1] = '{1,  1'b0, 4, 32'd4, 3,  1'b0};
        tbl[2] = '{16, 1'b1, 3, 32'd3, 18, 1'b0};   // done on the last WAIT cycle
        tbl[3] = '{17, 1'b1, 2, 32'd0, 18, 1'b1};   // done one cycle late: ignored
        tbl[4] = '{0,  1'b0, 3, 32'd0, 18, 1'b1};
        tbl[5] = '{5,  1'b1, 2, 32'd2, 7,  1'b0};
        ct_v    = CT;
        ct_fold = ct_v[127:96] ^ ct_v[95:64] ^ ct_v[63:32] ^ ct_v[31:0];

        rst_n = 1'b0; work = 1'b0; enc = 1'b1; aes_done = 1'b0; aes_dout = '0;
        core_lat = 12; stray_en = 0; n_starts = 0; last_start = 0; last_gap = 0;
        model_reset();
        ticks(3);
        chk("rst_din", aes_din, SEED);
        chk("rst_enc", aes_enc, 1'b1);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        ticks(2);

        // first block and chaining
        work = 1'b1;
        tick();
        chk("t1_start_lat", aes_start, 1'b1);
        chk("t1_din_seed", aes_din, SEED);
        tick();
        chk("t1_single_pulse", aes_start, 1'b0);
        wait_start(40, "t1_second_start");
        chk("t1_din_ct", aes_din, CT);
        chk("t1_cnt", blk_cnt, 32'd1);
        chk("t1_sig", sig, ct_fold);
        for (int b = 0; b < 4; b++) begin
            wait_start(40, "t2_start");
            chk("t2_gap", last_gap, 14);
        end
        chk("t2_cnt", blk_cnt, 32'd5);
        work = 1'b0;
        wait_idle(40, "t2_idle");
        chk("t2_hold_cnt", blk_cnt, 32'd6);

        // stop during block 3, then restart
        work = 1'b1;
        for (int b = 0; b < 3; b++) wait_start(40, "t3_start");
        ticks(3);
        work = 1'b0;
        wait_idle(40, "t3_idle");
        chk("t3_cnt", blk_cnt, 32'd3);
        n0 = n_starts;
        ticks(20);
        chk("t3_no_restart", n_starts, n0);
        work = 1'b1;
        tick();
        chk("t3_restart", aes_start, 1'b1);
        chk("t3_din_seed", aes_din, SEED);
        chk("t3_cnt_clr", blk_cnt, 32'd0);
        chk("t3_sig_clr", sig, 32'd0);

        // enc change mid-block only applies at the next launch
        ticks(2);
        enc = 1'b0;
        tick();
        chk("t4_enc_held", aes_enc, 1'b1);
        wait_start(40, "t4_start2");
        chk("t4_din_ct", aes_din, CT);
        tick();
        chk("t4_enc_new", aes_enc, 1'b0);
        wait_start(40, "t4_start3");
        chk("t4_dec_result", aes_din, SEED);
        work = 1'b0;
        wait_idle(40, "t4_idle");

        // timeout
        core_lat = 0; enc = 1'b1; work = 1'b1;
        wait_start(5, "t5_start");
        s = cyc;
        ticks(TMO);
        chk("t5_no_err_yet", err, 1'b0);
        tick();
        chk("t5_err", err, 1'b1);
        chk("t5_idle", busy, 1'b0);
        core_lat = 12;
        tick();
        chk("t5_relaunch", aes_start, 1'b1);
        chk("t5_relaunch_cyc", cyc - s, TMO + 2);
        wait_start(40, "t5_next");
        chk("t5_err_sticky", err, 1'b1);
        work = 1'b0;
        wait_idle(40, "t5_idle2");
        work = 1'b1;
        tick();
        chk("t5_err_clr", err, 1'b0);

        // asynchronous reset mid-WAIT and during LAUNCH, then counter wrap
        wait_start(40, "t6_b2");
        wait_start(40, "t6_b3");
        ticks(3);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_cnt", blk_cnt, 32'd0);
        chk("t6_rst_sig", sig, 32'd0);
        chk("t6_rst_din", aes_din, SEED);
        ticks(2);
        rst_n = 1'b1;
        tick();
        chk("t6_launch", aes_start, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_start_async", aes_start, 1'b0);
        ticks(2);
        rst_n = 1'b1;
        wait_start(5, "t6_restart");
        ticks(2);
        force dut.r_blk_cnt = 32'hFFFF_FFFF;
        release dut.r_blk_cnt;
        e_cnt = 32'hFFFF_FFFF;
        tick();
        chk("t6_preload", blk_cnt, 32'hFFFF_FFFF);
        wait_start(40, "t6_wrap_start");
        chk("t6_wrap", blk_cnt, 32'd0);
        work = 1'b0;
        wait_idle(40, "t6_idle");

        foreach (tbl[i]) begin
            enc = tbl[i].enc; core_lat = tbl[i].lat; work = 1'b1; n_starts = 0;
            for (int b = 0; b < tbl[i].nblk; b++) wait_start(60, "vec_start");
            work = 1'b0;
            wait_idle(60, "vec_idle");
            chk("vec_cnt", blk_cnt, tbl[i].exp_cnt);
            chk("vec_err", err, tbl[i].exp_err);
            chk("vec_gap", last_gap, tbl[i].exp_gap);
            ticks(2);
        end

        stray_en = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) work = ~work;
            if ($urandom_range(0, 9) == 0)  enc = ~enc;
            core_lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 18));
            rst_n = ($urandom_range(0, 699) != 0);
            tick();
        end
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
